// File: rtl/branch_search_seq.sv
// Bracket-matching branch-search sequencer: arms a forward/backward skip on '['/']' and counts nesting depth.
// Latency: search state, depth and flags register one cycle after the triggering handshake; exec_enable is combinational.
// Backpressure: instr_ready drops for the one-cycle DONE bubble and permanently in ERR (until reset).
// Optional feature macro: BRANCH_STATS_EN adds search_cycles / search_count statistics outputs.
module branch_search_seq #(
  parameter logic [8:0] OP_OPEN  = 9'h1F0,
  parameter logic [8:0] OP_CLOSE = 9'h1F1,
  parameter int         DEPTH_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8:0]         instruction,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [7:0]         working_value,
  output logic               exec_enable,
  output logic               searching,
  output logic               search_dir,
  output logic               pop_bubble,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]        search_cycles,
  output logic [7:0]         search_count
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    BWD  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nxt;
  logic [DEPTH_W-1:0] depth_nxt;
  logic               dir_nxt;
  logic               ovf_nxt;
  logic               handshake;
  logic               is_open;
  logic               is_close;
  logic               deepen;
  logic               shallow;

  assign is_open     = (instruction == OP_OPEN);
  assign is_close    = (instruction == OP_CLOSE);
  assign instr_ready = (state == IDLE) || (state == FWD) || (state == BWD);
  assign handshake   = instr_valid && instr_ready;
  assign searching   = (state == FWD) || (state == BWD);
  assign pop_bubble  = (state == DONE);

  // Only ordinary instructions seen outside a search may commit; brackets never do.
  assign exec_enable = handshake && (state == IDLE) && !is_open && !is_close;

  // In a forward walk '[' nests deeper and ']' unwinds; a backward walk swaps the roles.
  assign deepen  = (state == FWD) ? is_open  : is_close;
  assign shallow = (state == FWD) ? is_close : is_open;

  // Next-state, depth, direction and error decode.
  always_comb begin
    state_nxt = state;
    depth_nxt = depth;
    dir_nxt   = search_dir;
    ovf_nxt   = overflow;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (is_open && (working_value == 8'h00)) begin
            state_nxt = FWD;
            depth_nxt = DEPTH_ONE;
            dir_nxt   = 1'b0;
          end else if (is_close && (working_value != 8'h00)) begin
            state_nxt = BWD;
            depth_nxt = DEPTH_ONE;
            dir_nxt   = 1'b1;
          end
        end
      end
      FWD, BWD: begin
        if (handshake) begin
          if (deepen) begin
            if (depth == DEPTH_MAX) begin
              // Nesting deeper than the counter can hold: freeze depth and lock up.
              ovf_nxt   = 1'b1;
              state_nxt = ERR;
            end else begin
              depth_nxt = depth + DEPTH_ONE;
            end
          end else if (shallow) begin
            if (depth == DEPTH_ONE) begin
              depth_nxt = '0;
              state_nxt = DONE;
            end else begin
              depth_nxt = depth - DEPTH_ONE;
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // State, depth, direction and sticky overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      depth      <= '0;
      search_dir <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      depth      <= depth_nxt;
      search_dir <= dir_nxt;
      overflow   <= ovf_nxt;
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating count of cycles spent walking, and wrapping count of finished searches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      search_cycles <= 16'h0000;
      search_count  <= 8'h00;
    end else begin
      if (searching && (search_cycles != 16'hFFFF)) begin
        search_cycles <= search_cycles + 16'h0001;
      end
      if (state == DONE) begin
        search_count <= search_count + 8'h01;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_search_seq.sv
module tb_branch_search_seq;

  localparam logic [8:0] OPN = 9'h1F0;
  localparam logic [8:0] CLS = 9'h1F1;
  localparam int         MAXD = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] instruction;
  logic       instr_valid;
  logic [7:0] working_value;
  logic       instr_ready, exec_enable, searching, search_dir, pop_bubble, overflow;
  logic [7:0] depth;

  logic       s_rst;
  logic [8:0] s_instr;
  logic       s_vld;
  logic [7:0] s_w;
  logic       s_ready, s_exec, s_search, s_dir, s_pop, s_ovf;
  logic [1:0] s_depth;

`ifdef BRANCH_STATS_EN
  logic [15:0] search_cycles, s_cycles;
  logic [7:0]  search_count, s_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state (abstract: mode 0 idle, 1 walking, 2 done bubble, 3 error)
  int m_mode, m_dir, m_depth, m_ovf, m_cyc, m_cnt;

  always #5 clk = ~clk;

  branch_search_seq #(.OP_OPEN(OPN), .OP_CLOSE(CLS), .DEPTH_W(8)) dut (
    .clk(clk), .reset(rst), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .working_value(working_value), .exec_enable(exec_enable),
    .searching(searching), .search_dir(search_dir), .pop_bubble(pop_bubble),
    .depth(depth), .overflow(overflow)
`ifdef BRANCH_STATS_EN
    , .search_cycles(search_cycles), .search_count(search_count)
`endif
  );

  branch_search_seq #(.OP_OPEN(OPN), .OP_CLOSE(CLS), .DEPTH_W(2)) dut_small (
    .clk(clk), .reset(s_rst), .instruction(s_instr), .instr_valid(s_vld),
    .instr_ready(s_ready), .working_value(s_w), .exec_enable(s_exec),
    .searching(s_search), .search_dir(s_dir), .pop_bubble(s_pop),
    .depth(s_depth), .overflow(s_ovf)
`ifdef BRANCH_STATS_EN
    , .search_cycles(s_cycles), .search_count(s_count)
`endif
  );

  typedef struct {
    logic [8:0] instr;
    logic       vld;
    logic [7:0] w;
    logic       rdy;
    logic       ex;
    logic       srch;
    logic       dir;
    logic       pop;
    int         dep;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic [8:0] i, input logic v, input logic [7:0] w,
                     input logic rdy, input logic ex, input logic srch,
                     input logic dir, input logic pop, input int dep);
    vec_t t;
    t.instr = i; t.vld = v; t.w = w; t.rdy = rdy; t.ex = ex;
    t.srch = srch; t.dir = dir; t.pop = pop; t.dep = dep;
    tbl.push_back(t);
  endtask

  task automatic model_reset();
    m_mode = 0; m_dir = 0; m_depth = 0; m_ovf = 0; m_cyc = 0; m_cnt = 0;
  endtask

  // Compare every DUT output against the model for the inputs currently applied.
  task automatic check_model(input string tag);
    int exp_ex;
    exp_ex = (instr_valid && m_mode == 0 && instruction != OPN && instruction != CLS) ? 1 : 0;
    chk({tag, ".ready"},  int'(instr_ready), (m_mode <= 1) ? 1 : 0);
    chk({tag, ".exec"},   int'(exec_enable), exp_ex);
    chk({tag, ".search"}, int'(searching),   (m_mode == 1) ? 1 : 0);
    chk({tag, ".pop"},    int'(pop_bubble),  (m_mode == 2) ? 1 : 0);
    chk({tag, ".dir"},    int'(search_dir),  m_dir);
    chk({tag, ".depth"},  int'(depth),       m_depth);
    chk({tag, ".ovf"},    int'(overflow),    m_ovf);
`ifdef BRANCH_STATS_EN
    chk({tag, ".cycles"}, int'(search_cycles), m_cyc);
    chk({tag, ".count"},  int'(search_count),  m_cnt);
`endif
  endtask

  // Advance the model across one clock edge using the inputs applied this cycle.
  task automatic model_step();
    bit hs;
    bit deeper, shallower;
    hs = instr_valid && (m_mode <= 1);
    if (m_mode == 1) m_cyc = (m_cyc < 65535) ? m_cyc + 1 : 65535;
    if (m_mode == 2) m_cnt = (m_cnt + 1) % 256;
    if (m_mode == 2) begin
      m_mode = 0;
    end else if (hs && m_mode == 0) begin
      if (instruction == OPN && working_value == 0) begin
        m_mode = 1; m_dir = 0; m_depth = 1;
      end else if (instruction == CLS && working_value != 0) begin
        m_mode = 1; m_dir = 1; m_depth = 1;
      end
    end else if (hs && m_mode == 1) begin
      deeper    = (instruction == (m_dir ? CLS : OPN));
      shallower = (instruction == (m_dir ? OPN : CLS));
      if (deeper) begin
        if (m_depth == MAXD) begin
          m_ovf = 1; m_mode = 3;
        end else begin
          m_depth++;
        end
      end else if (shallower) begin
        m_depth--;
        if (m_depth == 0) m_mode = 2;
      end
    end
  endtask

  // One cycle on the main instance: drive, settle, return to caller for checks via flag.
  task automatic apply(input logic [8:0] i, input logic v, input logic [7:0] w, input bit use_model);
    instruction = i; instr_valid = v; working_value = w;
    #2;
    if (use_model) check_model("rnd");
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1; s_rst = 1'b1;
    instruction = 9'h000; instr_valid = 1'b0; working_value = 8'h00;
    s_instr = 9'h000; s_vld = 1'b0; s_w = 8'h00;
    model_reset();
    #2;
    chk("rst.ready",  int'(instr_ready), 1);
    chk("rst.search", int'(searching),   0);
    chk("rst.dir",    int'(search_dir),  0);
    chk("rst.pop",    int'(pop_bubble),  0);
    chk("rst.depth",  int'(depth),       0);
    chk("rst.ovf",    int'(overflow),    0);
    @(posedge clk); #1;
    rst = 1'b0; s_rst = 1'b0;

    // Overflow on a 2-bit depth counter, then asynchronous reset out of ERR.
    s_instr = OPN; s_vld = 1'b1; s_w = 8'h00;
    @(posedge clk); #1;
    chk("sm.depth1", int'(s_depth), 1);
    @(posedge clk); #1;
    chk("sm.depth2", int'(s_depth), 2);
    @(posedge clk); #1;
    chk("sm.depth3", int'(s_depth), 3);
    chk("sm.ovf_pre", int'(s_ovf), 0);
    @(posedge clk); #1;
    chk("sm.sat_depth", int'(s_depth), 3);
    chk("sm.ovf",       int'(s_ovf), 1);
    chk("sm.err_ready", int'(s_ready), 0);
    chk("sm.err_srch",  int'(s_search), 0);
    s_instr = 9'h004;
    #1;
    chk("sm.err_exec", int'(s_exec), 0);
    @(posedge clk); #1;
    chk("sm.err_hold", int'(s_ready), 0);
    #1;
    s_rst = 1'b1;
    #1;
    chk("sm.arst_depth", int'(s_depth), 0);
    chk("sm.arst_ovf",   int'(s_ovf), 0);
    chk("sm.arst_ready", int'(s_ready), 1);
    chk("sm.arst_srch",  int'(s_search), 0);
    chk("sm.arst_pop",   int'(s_pop), 0);
    chk("sm.arst_dir",   int'(s_dir), 0);
    s_vld = 1'b0;
    @(posedge clk); #1;
    s_rst = 1'b0;

    // Directed vector table for the main instance (outputs seen during the row's cycle).
    //   instr  vld w      rdy ex srch dir pop dep
    add(OPN,    1, 8'h00, 1, 0, 0, 0, 0, 0);
    add(9'h004, 1, 8'h00, 1, 0, 1, 0, 0, 1);
    add(CLS,    1, 8'h00, 1, 0, 1, 0, 0, 1);
    add(9'h004, 1, 8'h00, 0, 0, 0, 0, 1, 0);
    add(9'h004, 1, 8'h00, 1, 1, 0, 0, 0, 0);
    add(OPN,    1, 8'h00, 1, 0, 0, 0, 0, 0);
    add(OPN,    1, 8'h00, 1, 0, 1, 0, 0, 1);
    add(OPN,    1, 8'h00, 1, 0, 1, 0, 0, 2);
    add(CLS,    1, 8'h00, 1, 0, 1, 0, 0, 3);
    add(CLS,    1, 8'h00, 1, 0, 1, 0, 0, 2);
    add(CLS,    1, 8'h00, 1, 0, 1, 0, 0, 1);
    add(9'h003, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    add(OPN,    1, 8'h05, 1, 0, 0, 0, 0, 0);
    add(9'h002, 1, 8'h05, 1, 1, 0, 0, 0, 0);
    add(CLS,    1, 8'h01, 1, 0, 0, 0, 0, 0);
    add(CLS,    1, 8'h01, 1, 0, 1, 1, 0, 1);
    add(OPN,    1, 8'h01, 1, 0, 1, 1, 0, 2);
    add(OPN,    1, 8'h01, 1, 0, 1, 1, 0, 1);
    add(9'h000, 0, 8'h00, 0, 0, 0, 1, 1, 0);
    add(9'h001, 0, 8'h00, 1, 0, 0, 1, 0, 0);
    add(OPN,    1, 8'h00, 1, 0, 0, 1, 0, 0);
    add(OPN,    1, 8'h00, 1, 0, 1, 0, 0, 1);
    add(CLS,    0, 8'h00, 1, 0, 1, 0, 0, 2);
    add(CLS,    0, 8'h00, 1, 0, 1, 0, 0, 2);
    add(CLS,    0, 8'h00, 1, 0, 1, 0, 0, 2);
    add(CLS,    0, 8'h00, 1, 0, 1, 0, 0, 2);
    add(CLS,    1, 8'h00, 1, 0, 1, 0, 0, 2);
    add(CLS,    1, 8'h00, 1, 0, 1, 0, 0, 1);
    add(9'h000, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    add(9'h000, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(CLS,    1, 8'h00, 1, 0, 0, 0, 0, 0);
    add(9'h000, 0, 8'h00, 1, 0, 0, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].instr, tbl[k].vld, tbl[k].w, 1'b0);
      chk($sformatf("tbl%0d.ready", k),  int'(instr_ready), int'(tbl[k].rdy));
      chk($sformatf("tbl%0d.exec", k),   int'(exec_enable), int'(tbl[k].ex));
      chk($sformatf("tbl%0d.search", k), int'(searching),   int'(tbl[k].srch));
      chk($sformatf("tbl%0d.dir", k),    int'(search_dir),  int'(tbl[k].dir));
      chk($sformatf("tbl%0d.pop", k),    int'(pop_bubble),  int'(tbl[k].pop));
      chk($sformatf("tbl%0d.depth", k),  int'(depth),       tbl[k].dep);
      chk($sformatf("tbl%0d.ovf", k),    int'(overflow),    0);
`ifdef BRANCH_STATS_EN
      chk($sformatf("tbl%0d.cycles", k), int'(search_cycles), m_cyc);
      chk($sformatf("tbl%0d.count", k),  int'(search_count),  m_cnt);
`endif
      finish_cycle();
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [8:0] ri;
      logic [7:0] rw;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)      ri = OPN;
      else if (sel < 8) ri = CLS;
      else              ri = 9'($urandom_range(0, 511));
      rw = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      apply(ri, ($urandom_range(0, 3) != 0), rw, 1'b1);
      finish_cycle();
    end

    // Force a search, then reset mid-walk: must drop to idle without a clock edge.
    apply(OPN, 1'b1, 8'h00, 1'b0);
    finish_cycle();
    if (m_mode == 3) begin
      apply(9'h000, 1'b0, 8'h00, 1'b0);
    end
    apply(OPN, 1'b1, 8'h00, 1'b0);
    finish_cycle();
    instr_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("arst");
    @(posedge clk); #1;
    rst = 1'b0;
    apply(9'h007, 1'b1, 8'h00, 1'b1);
    finish_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute runtime bound.
  initial begin
    #1000000;
    $display("FAIL timeout reached at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_search_seq.md
Name: branch_search_seq

Overview:
- Sequencer for bracket-matching branch searches on the BeeF core.
- Decides when a loop-open or loop-close instruction starts a forward or backward skip, then tracks nesting depth while the fetch stream walks.
- Gates datapath commit (exec_enable) and issues the pop_bubble pulse that ends the search.
- Sits between fetch and the ALU/register controllers; drives their searching/pop_bubble inputs.

Parameters:
- OP_OPEN, 9'h1F0, encoding of the loop-open ('[') instruction.
- OP_CLOSE, 9'h1F1, encoding of the loop-close (']') instruction.
- DEPTH_W, 8, nesting-depth counter width; max depth is 2^DEPTH_W-1.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instruction  input  9  current fetched instruction.
- instr_valid  input  1  instruction is valid this cycle.
- instr_ready  output  1  sequencer consumes the instruction this cycle. Handshake completes on instr_valid && instr_ready.
- working_value  input  8  working register value, used for branch condition.
- exec_enable  output  1  datapath may commit the current instruction.
- searching  output  1  search in progress.
- search_dir  output  1  0 = forward (skip to matching close), 1 = backward.
- pop_bubble  output  1  single-cycle pulse: search finished, flush one bubble.
- depth  output  DEPTH_W  current nesting depth; 0 when not searching.
- overflow  output  1  sticky error, depth exceeded the maximum.

Behaviour:
- States: IDLE, FWD, BWD, DONE, ERR. State and depth registers are asynchronous-reset.
- Reset values: state=IDLE, depth=0, searching=0, search_dir=0, pop_bubble=0, overflow=0.
- Reset mid-search aborts immediately to IDLE.
- instr_ready = 1 in IDLE/FWD/BWD; 0 in DONE/ERR.
- A handshake is one cycle with instr_valid && instr_ready; with no handshake, state and depth hold.
- exec_enable = handshake && state==IDLE && instruction is neither OP_OPEN nor OP_CLOSE.
  - Branch opcodes never commit.
  - exec_enable is combinational from inputs; all other outputs are registered/state-decoded.
- IDLE, on handshake:
  - OP_OPEN with working_value==0 -> FWD, depth=1, search_dir=0.
  - OP_CLOSE with working_value!=0 -> BWD, depth=1, search_dir=1.
  - Any other opcode or condition: stay in IDLE.
- searching = (state==FWD || state==BWD). It rises the cycle after the triggering handshake.
- FWD, on handshake:
  - OP_OPEN: depth+1.
  - OP_CLOSE with depth==1: depth=0 -> DONE.
  - OP_CLOSE otherwise: depth-1.
  - Other opcodes: ignored.
- BWD: mirror of FWD. OP_CLOSE increments; OP_OPEN with depth==1 -> DONE; OP_OPEN otherwise decrements.
- DONE: lasts exactly one cycle. pop_bubble=1, searching=0, instruction not consumed. Next state IDLE.
- Depth increment when depth==2^DEPTH_W-1: depth holds (saturates), overflow latches to 1, state -> ERR.
- ERR: instr_ready=0, exec_enable=0, searching=0. Left only by reset.
- Width rule: depth arithmetic is DEPTH_W unsigned. Decrement never goes below 0, because depth==1 always exits to DONE.
- instr_valid low during search: depth and state hold, pop_bubble stays 0.
- Backward direction: the fetch unit reverses PC direction on search_dir; this block only counts.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined:
  - Adds output search_cycles [15:0]: count of cycles spent in FWD/BWD since reset.
  - Counter saturates at 16'hFFFF and resets to 0.
  - Adds output search_count [7:0]: number of completed searches (DONE entries). Wraps modulo 256.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then OP_OPEN with working_value=8'h00 -> next cycle searching=1, search_dir=0, depth=1. Feed 9'h004 then OP_CLOSE -> DONE: pop_bubble=1 for exactly one cycle, instr_ready=0 that cycle, then IDLE.
- Nested forward: OP_OPEN (w=0), OP_OPEN, OP_OPEN, OP_CLOSE, OP_CLOSE, OP_CLOSE -> depth sequence 1,2,3,2,1,0. pop_bubble only after the third close.
- OP_OPEN with working_value=8'h05 -> stays IDLE, searching=0, exec_enable=0 for that cycle. Next 9'h002 -> exec_enable=1.
- Backward: OP_CLOSE with w=8'h01, then OP_CLOSE, OP_OPEN, OP_OPEN -> search_dir=1, depth 1,2,1,0, then DONE.
- DEPTH_W=2: forward search plus 3 OP_OPENs -> depth saturates at 3, overflow=1, state ERR, instr_ready=0. Assert reset mid-ERR -> all outputs return to reset values asynchronously, before the next clk edge.
- instr_valid deasserted for 4 cycles mid-FWD at depth=2 -> depth holds at 2, no pop_bubble. With BRANCH_STATS_EN, search_cycles still increments by 4.
